// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl_pkg
// Description : Shared constants for the machine-mode trap sequencer: CSR
//               addresses, trap-type encodings, mstatus bit positions and
//               sequencer state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package trap_ctrl_pkg;

    // CSR addresses touched by the sequencer
    localparam logic [11:0] c_CSR_MSTATUS = 12'h300;
    localparam logic [11:0] c_CSR_MTVEC   = 12'h305;
    localparam logic [11:0] c_CSR_MEPC    = 12'h341;
    localparam logic [11:0] c_CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] c_CSR_MTVAL   = 12'h343;

    // trap_type encodings (11 is reserved and ignored)
    localparam logic [1:0] c_TT_EXC  = 2'b00;
    localparam logic [1:0] c_TT_MRET = 2'b01;
    localparam logic [1:0] c_TT_IRQ  = 2'b10;

    // mstatus bit positions
    localparam int c_MIE_BIT  = 3;
    localparam int c_MPIE_BIT = 7;
    localparam int c_MPP_LO   = 11;
    localparam int c_MPP_HI   = 12;

    // Sequencer states
    localparam int c_STATE_W = 4;
    localparam logic [c_STATE_W-1:0] c_S_IDLE       = 4'd0;
    localparam logic [c_STATE_W-1:0] c_S_E_MEPC     = 4'd1;
    localparam logic [c_STATE_W-1:0] c_S_E_MCAUSE   = 4'd2;
    localparam logic [c_STATE_W-1:0] c_S_E_MTVAL    = 4'd3;
    localparam logic [c_STATE_W-1:0] c_S_E_RMTVEC   = 4'd4;
    localparam logic [c_STATE_W-1:0] c_S_E_RMSTATUS = 4'd5;
    localparam logic [c_STATE_W-1:0] c_S_E_WMSTATUS = 4'd6;
    localparam logic [c_STATE_W-1:0] c_S_X_RMSTATUS = 4'd7;
    localparam logic [c_STATE_W-1:0] c_S_X_RMEPC    = 4'd8;
    localparam logic [c_STATE_W-1:0] c_S_X_WMSTATUS = 4'd9;
    localparam logic [c_STATE_W-1:0] c_S_DONE       = 4'd10;

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : irq_prio_enc
// Description : Fixed-priority interrupt encoder. Lowest set index wins and
//               selects its 4-bit mcause code from the packed code table.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter int                   NUM_IRQ   = 3,
    parameter logic [4*NUM_IRQ-1:0] IRQ_CODES = {4'd11, 4'd3, 4'd7},
    parameter int                   IDX_W     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] i_pending,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_index,
    output logic [3:0]         o_code
);

    // Scan from highest to lowest index so the lowest set source is kept last
    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        o_code  = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_pending[i]) begin
                o_valid = 1'b1;
                o_index = IDX_W'(i);
                o_code  = IRQ_CODES[4*i +: 4];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Machine-mode trap sequencer. Runs the serial CSR read/write
//               sequence for exception/interrupt entry and mret, then
//               redirects the PC and hands completion to the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int                   XLEN      = 64,
    parameter int                   NUM_IRQ   = 3,
    parameter logic [4*NUM_IRQ-1:0] IRQ_CODES = {4'd11, 4'd3, 4'd7},
    parameter bit                   HAS_MTVAL = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_ena,
    input  logic [1:0]         i_trap_type,
    input  logic [3:0]         i_exc_code,
    input  logic [XLEN-1:0]    i_tval,
    input  logic [XLEN-1:0]    i_pc,
    input  logic [NUM_IRQ-1:0] i_irq_pending,
    output logic               o_busy,
    output logic               o_req,
    input  logic               i_ack,
    output logic               o_pc_jmp,
    output logic [XLEN-1:0]    o_pc_jmpaddr,
    output logic [11:0]        o_csr_addr,
    output logic               o_csr_ren,
    output logic               o_csr_wen,
    output logic [XLEN-1:0]    o_csr_wdata,
    input  logic [XLEN-1:0]    i_csr_rdata,
    input  logic               i_csr_ready
);

    localparam int c_IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next;
    logic [XLEN-1:0]      r_pc, r_tval, r_mtvec, r_mstatus, r_mepc, r_pc_jmpaddr;
    logic                 r_irq, r_pc_jmp;
    logic [3:0]           r_code;
    logic                 w_capture, w_is_irq, w_done;
    logic                 w_irq_valid;
    logic [3:0]           w_irq_code;
    logic [c_IDX_W-1:0]   w_unused_irq_idx;
    logic [XLEN-1:0]      w_cause, w_mst_entry, w_mst_ret;
    logic [XLEN-1:0]      w_vec_base, w_entry_tgt, w_ret_tgt;

    irq_prio_enc #(
        .NUM_IRQ   (NUM_IRQ),
        .IRQ_CODES (IRQ_CODES),
        .IDX_W     (c_IDX_W)
    ) u_prio (
        .i_pending (i_irq_pending),
        .o_valid   (w_irq_valid),
        .o_index   (w_unused_irq_idx),
        .o_code    (w_irq_code)
    );

    assign w_is_irq   = (i_trap_type == c_TT_IRQ);
    assign w_cause    = {r_irq, {(XLEN-5){1'b0}}, r_code};
    assign w_vec_base = {r_mtvec[XLEN-1:2], 2'b00};
    assign w_ret_tgt  = {r_mepc[XLEN-1:2], 2'b00};
    // Vectored mode only applies to interrupts; sum wraps at XLEN bits
    assign w_entry_tgt = ((r_mtvec[1:0] == 2'b01) && r_irq)
                       ? w_vec_base + {{(XLEN-6){1'b0}}, r_code, 2'b00}
                       : w_vec_base;

    // mstatus rewrite values for trap entry and for mret
    always_comb begin
        w_mst_entry              = r_mstatus;
        w_mst_entry[c_MPIE_BIT]  = r_mstatus[c_MIE_BIT];
        w_mst_entry[c_MIE_BIT]   = 1'b0;
        w_mst_entry[c_MPP_HI:c_MPP_LO] = 2'b11;
        w_mst_ret                = r_mstatus;
        w_mst_ret[c_MIE_BIT]     = r_mstatus[c_MPIE_BIT];
        w_mst_ret[c_MPIE_BIT]    = 1'b1;
        w_mst_ret[c_MPP_HI:c_MPP_LO] = 2'b11;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state and CSR port decode; CSR outputs depend only on held state
    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_done      = 1'b0;
        o_csr_addr  = 12'h000;
        o_csr_ren   = 1'b0;
        o_csr_wen   = 1'b0;
        o_csr_wdata = '0;
        case (r_state)
            c_S_IDLE: begin
                if (i_ena) begin
                    if (i_trap_type == c_TT_EXC) begin
                        w_capture = 1'b1;
                        w_next    = c_S_E_MEPC;
                    end else if (i_trap_type == c_TT_MRET) begin
                        w_capture = 1'b1;
                        w_next    = c_S_X_RMSTATUS;
                    end else if (w_is_irq && w_irq_valid) begin
                        w_capture = 1'b1;
                        w_next    = c_S_E_MEPC;
                    end
                end
            end
            c_S_E_MEPC: begin
                o_csr_addr  = c_CSR_MEPC;
                o_csr_wen   = 1'b1;
                o_csr_wdata = r_pc;
                if (i_csr_ready) w_next = c_S_E_MCAUSE;
            end
            c_S_E_MCAUSE: begin
                o_csr_addr  = c_CSR_MCAUSE;
                o_csr_wen   = 1'b1;
                o_csr_wdata = w_cause;
                if (i_csr_ready) w_next = HAS_MTVAL ? c_S_E_MTVAL : c_S_E_RMTVEC;
            end
            c_S_E_MTVAL: begin
                o_csr_addr  = c_CSR_MTVAL;
                o_csr_wen   = 1'b1;
                o_csr_wdata = r_tval;
                if (i_csr_ready) w_next = c_S_E_RMTVEC;
            end
            c_S_E_RMTVEC: begin
                o_csr_addr = c_CSR_MTVEC;
                o_csr_ren  = 1'b1;
                if (i_csr_ready) w_next = c_S_E_RMSTATUS;
            end
            c_S_E_RMSTATUS: begin
                o_csr_addr = c_CSR_MSTATUS;
                o_csr_ren  = 1'b1;
                if (i_csr_ready) w_next = c_S_E_WMSTATUS;
            end
            c_S_E_WMSTATUS: begin
                o_csr_addr  = c_CSR_MSTATUS;
                o_csr_wen   = 1'b1;
                o_csr_wdata = w_mst_entry;
                if (i_csr_ready) begin
                    w_done = 1'b1;
                    w_next = c_S_DONE;
                end
            end
            c_S_X_RMSTATUS: begin
                o_csr_addr = c_CSR_MSTATUS;
                o_csr_ren  = 1'b1;
                if (i_csr_ready) w_next = c_S_X_RMEPC;
            end
            c_S_X_RMEPC: begin
                o_csr_addr = c_CSR_MEPC;
                o_csr_ren  = 1'b1;
                if (i_csr_ready) w_next = c_S_X_WMSTATUS;
            end
            c_S_X_WMSTATUS: begin
                o_csr_addr  = c_CSR_MSTATUS;
                o_csr_wen   = 1'b1;
                o_csr_wdata = w_mst_ret;
                if (i_csr_ready) begin
                    w_done = 1'b1;
                    w_next = c_S_DONE;
                end
            end
            c_S_DONE: begin
                if (i_ack) w_next = c_S_IDLE;
            end
            default: w_next = c_S_IDLE;
        endcase
    end

    // Capture trap context, read-back CSR values and the redirect target
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc         <= '0;
            r_tval       <= '0;
            r_irq        <= 1'b0;
            r_code       <= 4'd0;
            r_mtvec      <= '0;
            r_mstatus    <= '0;
            r_mepc       <= '0;
            r_pc_jmp     <= 1'b0;
            r_pc_jmpaddr <= '0;
        end else begin
            r_pc_jmp <= w_done;
            if (w_capture) begin
                r_pc   <= i_pc;
                r_tval <= w_is_irq ? '0 : i_tval;
                r_irq  <= w_is_irq;
                r_code <= w_is_irq ? w_irq_code : i_exc_code;
            end
            if (i_csr_ready) begin
                case (r_state)
                    c_S_E_RMTVEC:                   r_mtvec   <= i_csr_rdata;
                    c_S_E_RMSTATUS, c_S_X_RMSTATUS: r_mstatus <= i_csr_rdata;
                    c_S_X_RMEPC:                    r_mepc    <= i_csr_rdata;
                    default: ;
                endcase
            end
            if (w_done)
                r_pc_jmpaddr <= (r_state == c_S_X_WMSTATUS) ? w_ret_tgt : w_entry_tgt;
        end
    end

    assign o_busy       = (r_state != c_S_IDLE);
    assign o_req        = (r_state == c_S_DONE);
    assign o_pc_jmp     = r_pc_jmp;
    assign o_pc_jmpaddr = r_pc_jmpaddr;

endmodule
`default_nettype wire
